// File: rtl/dds_pkg.sv
// Shared parameter defaults and FSM encoding for the DDS phase accumulator.
package dds_pkg;

    localparam int unsigned ACC_WIDTH_DEF  = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 10;

    // Tuning-word controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } dds_state_e;

endpackage

// File: rtl/dds_tune_ctrl.sv
// Tuning-word handshake and FSM. Holds the active FTW and defers a new word
// received while running until the next phase boundary (overflow, clear, or stop).
module dds_tune_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 sync_clear,
    input  logic                 carry_c,
    input  logic                 tune_valid,
    input  logic [ACC_WIDTH-1:0] tune_word,
    output logic                 tune_ready_c,
    output logic [ACC_WIDTH-1:0] ftw_active
);

    dds_state_e           state;
    dds_state_e           state_nxt;
    logic [ACC_WIDTH-1:0] ftw_pending;
    logic [ACC_WIDTH-1:0] ftw_pending_nxt;
    logic [ACC_WIDTH-1:0] ftw_active_nxt;
    logic                 xfer_c;

    // Ready whenever no word is parked; a transfer is valid && ready
    assign tune_ready_c = (state != PENDING);
    assign xfer_c       = tune_valid && tune_ready_c;

    // State and tuning-word registers; reset discards any pending word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ftw_active  <= '0;
            ftw_pending <= '0;
        end else begin
            state       <= state_nxt;
            ftw_active  <= ftw_active_nxt;
            ftw_pending <= ftw_pending_nxt;
        end
    end

    // Next-state and FTW selection
    always_comb begin
        state_nxt       = state;
        ftw_active_nxt  = ftw_active;
        ftw_pending_nxt = ftw_pending;
        case (state)
            IDLE: begin
                if (xfer_c) begin
                    ftw_active_nxt = tune_word;
                end
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Stopping is itself a phase boundary, so apply directly
                    state_nxt = IDLE;
                    if (xfer_c) begin
                        ftw_active_nxt = tune_word;
                    end
                end else if (xfer_c) begin
                    ftw_pending_nxt = tune_word;
                    state_nxt       = PENDING;
                end
            end
            PENDING: begin
                // Zero FTW would never overflow, so apply at once to avoid deadlock
                if (!enable || sync_clear || carry_c || (ftw_active == '0)) begin
                    ftw_active_nxt = ftw_pending;
                    state_nxt      = enable ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: accumulates the active FTW and produces a registered
// LUT address from the top accumulator bits plus a phase offset.
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sync_clear,
    input  logic                  tune_valid,
    input  logic [ACC_WIDTH-1:0]  tune_word,
    output logic                  tune_ready,
    input  logic [ADDR_WIDTH-1:0] phase_offset,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic                  sample_valid,
    output logic                  wrap
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] ftw_active;
    logic [ACC_WIDTH:0]   sum_c;
    logic                 carry_c;

    // Extended sum exposes the overflow carry
    assign sum_c   = {1'b0, acc} + {1'b0, ftw_active};
    assign carry_c = enable && sum_c[ACC_WIDTH];

    dds_tune_ctrl #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_tune_ctrl (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .sync_clear   (sync_clear),
        .carry_c      (carry_c),
        .tune_valid   (tune_valid),
        .tune_word    (tune_word),
        .tune_ready_c (tune_ready),
        .ftw_active   (ftw_active)
    );

    // Phase accumulator; clear has priority over advance
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (sync_clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum_c[ACC_WIDTH-1:0];
        end
    end

    // Address, valid pipeline and wrap pulse from the pre-update accumulator
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= '0;
            addr_valid   <= 1'b0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            addr         <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset;
            addr_valid   <= enable;
            sample_valid <= addr_valid;
            wrap         <= carry_c && !sync_clear;
        end
    end

endmodule

// File: doc/dds_phase_accumulator.md
DDS_PHASE_ACCUMULATOR -- requirements
Module: dds_phase_accumulator

Interface
REQ-001 Parameter ACC_WIDTH, default 32: phase accumulator width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: LUT address width; the top ADDR_WIDTH accumulator bits form the address.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = accumulator advances and the address stream is valid.
REQ-006 sync_clear  input  1  single-cycle request to zero the phase.
REQ-007 tune_valid  input  1  a new frequency tuning word is offered.
REQ-008 tune_word  input  ACC_WIDTH  frequency tuning word (FTW).
REQ-009 tune_ready  output  1  block can accept a tuning word; a transfer occurs when tune_valid and tune_ready are both high on a rising edge.
REQ-010 phase_offset  input  ADDR_WIDTH  static address offset, sampled every cycle.
REQ-011 addr  output  ADDR_WIDTH  registered LUT address, driving the 10-bit LUT addr input directly.
REQ-012 addr_valid  output  1  addr is a valid sample address.
REQ-013 sample_valid  output  1  addr_valid delayed one cycle; aligned with the 1-cycle-latency LUT output.
REQ-014 wrap  output  1  registered single-cycle pulse, high the cycle after the accumulator overflows.

Function
REQ-015 acc SHALL be updated as acc <= (acc + ftw_active) mod 2^ACC_WIDTH on each edge where enable=1, and SHALL hold when enable=0.
REQ-016 addr SHALL be updated as addr <= (acc[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset) mod 2^ADDR_WIDTH using the pre-update acc; addr_valid <= enable; sample_valid <= addr_valid.
REQ-017 Overflow SHALL be defined as the carry-out of acc + ftw_active on an enabled cycle; wrap <= that carry, else 0.
REQ-018 The FSM SHALL have exactly three states. IDLE: enable=0. RUN: enable=1, nothing pending. PENDING: enable=1, a tuning word is held in ftw_pending.
REQ-019 tune_ready SHALL equal (state != PENDING), combinationally from the state register.
REQ-020 A transfer in IDLE SHALL write ftw_active directly; a transfer in RUN SHALL write ftw_pending and move the FSM to PENDING.
REQ-021 In PENDING, on the first enabled overflow cycle, ftw_active <= ftw_pending and state -> RUN; that cycle's increment SHALL still use the old ftw_active, giving a phase-continuous switch at the wrap.
REQ-022 In PENDING with ftw_active == 0, the pending word SHALL be applied on the next edge, so the block cannot deadlock.
REQ-023 If enable falls in PENDING, the pending word SHALL be applied on that edge and state -> IDLE.
REQ-024 IDLE->RUN SHALL occur on enable=1 and RUN->IDLE on enable=0, with no change to acc beyond REQ-015.
REQ-025 sync_clear=1 SHALL force acc <= 0, overriding REQ-015; wrap SHALL be 0 that cycle. If the FSM is PENDING, the pending word SHALL be applied on the same edge (the clear counts as a phase boundary).
REQ-026 A tune_valid held while tune_ready=0 SHALL NOT be consumed; tune_word SHALL NOT be sampled until the transfer edge.

Reset
REQ-027 While reset_n=0: acc=0, ftw_active=0, ftw_pending=0, state=IDLE, addr=0, addr_valid=0, sample_valid=0, wrap=0; tune_ready therefore reads 1.
REQ-028 Reset assertion mid-operation, including in PENDING, SHALL discard any pending word immediately, without waiting for a clock edge.

Structure
REQ-029 The shared package dds_pkg SHALL hold ACC_WIDTH, ADDR_WIDTH defaults and the FSM state encoding (IDLE, RUN, PENDING).
REQ-030 The tuning handshake and FSM SHALL live in one sub-module, dds_tune_ctrl; the accumulator and address register SHALL stay in the top module.

Verification
REQ-031 Reset, then load FTW=0x0040_0000 in IDLE, then enable=1 -> addr sequence 0,1,2,…,1023,0; wrap high for one cycle after the addr-1023 cycle; sample_valid follows addr_valid by 1 cycle.
REQ-032 While running at FTW=0x0040_0000, offer FTW=0x0080_0000 -> tune_ready low until the next wrap; addr steps by 1 up to 1023, then by 2 from 0 (0,2,4…); the jump is phase-continuous.
REQ-033 With ftw_active=0 and enable=1, offer FTW=0x0100_0000 -> applied after one edge, addr steps by 4, tune_ready returns high.
REQ-034 Running with phase_offset=1023 and FTW=0x0040_0000 -> addr sequence 1023,0,1,…; wrap timing unchanged.
REQ-035 Assert sync_clear on the same cycle as an overflow while PENDING -> acc=0, wrap stays 0, new FTW active, state RUN.
REQ-036 Assert reset_n=0 asynchronously mid-cycle while PENDING -> all outputs 0 without waiting for an edge, tune_ready=1; after release, ftw_active=0.
